// File: rtl/fec_pkg.sv
// Shared types for the downlink scheduler: FSM state encoding,
// default requester count and the latched packet descriptor.
package fec_pkg;

    localparam int DL_SCHED_NUM_REQ = 4;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } dl_sched_state_t;

    typedef struct packed {
        logic       enc_used;
        logic [3:0] tag;
        logic [7:0] len;
    } dl_desc_t;

    function automatic dl_desc_t mk_desc(
        input logic       enc,
        input logic [3:0] tag,
        input logic [7:0] len
    );
        dl_desc_t d;
        d.enc_used = enc;
        d.tag      = tag;
        d.len      = len;
        return d;
    endfunction

endpackage

// File: rtl/dl_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set bit of
// req at or above ptr, wrapping. Ports: req, ptr in; gnt (one-hot),
// idx, valid out. The caller owns and advances the pointer.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        w_sum = '0;
        w_j   = '0;
        for (int i = 0; i < N; i++) begin
            // candidate index (ptr + i) mod N without a divider
            w_sum = {1'b0, ptr} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_j = w_sum[IW-1:0];
            if (!valid && req[w_j]) begin
                valid  = 1'b1;
                idx    = w_j;
                gnt[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dl_scheduler.sv
// dl_scheduler: round-robin share of one downlink controller among
// NUM_REQ requesters; latches the winner's descriptor, pulses
// dl_start, follows dl_done through busy/complete, then holds an
// optional inter-packet gap.
// Ports: clk, rst (sync, active high); req/req_enc_used/req_tag/
// req_len per requester; gap_cycles, wdog_cycles; req_ack/req_done/
// req_err one-hot pulses; dl_start, dl_enc_used, dl_msg_tag,
// dl_msg_len to the controller; dl_done from it; busy.
// Optional watchdog: define DL_SCHED_WDOG_EN.
module dl_scheduler
    import fec_pkg::*;
#(
    parameter int NUM_REQ    = DL_SCHED_NUM_REQ,
    parameter int GAP_WIDTH  = 8,
    parameter int WDOG_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_enc_used,
    input  logic [NUM_REQ*4-1:0]   req_tag,
    input  logic [NUM_REQ*8-1:0]   req_len,
    input  logic [GAP_WIDTH-1:0]   gap_cycles,
    input  logic [WDOG_WIDTH-1:0]  wdog_cycles,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_err,
    output logic                   dl_start,
    output logic                   dl_enc_used,
    output logic [3:0]             dl_msg_tag,
    output logic [7:0]             dl_msg_len,
    input  logic                   dl_done,
    output logic                   busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    dl_sched_state_t      r_state;
    dl_sched_state_t      w_next;
    logic [IW-1:0]        r_ptr;
    logic [IW-1:0]        r_cur_idx;
    logic [GAP_WIDTH-1:0] r_gap_cnt;
    dl_desc_t             r_desc;
    dl_desc_t             w_sel_desc;
    logic                 r_start;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   r_done;
    logic [NUM_REQ-1:0]   r_err;

    logic [NUM_REQ-1:0]   w_gnt;
    logic [IW-1:0]        w_idx;
    logic                 w_valid;

    logic                 w_grant;
    logic                 w_complete;
    logic                 w_expire;
    logic                 w_finish;
    logic                 w_gap_en;
    logic [NUM_REQ-1:0]   w_cur_oh;
    logic [NUM_REQ-1:0]   w_ack_nxt;
    logic [NUM_REQ-1:0]   w_done_nxt;
    logic [NUM_REQ-1:0]   w_err_nxt;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req   (req),
        .ptr   (r_ptr),
        .gnt   (w_gnt),
        .idx   (w_idx),
        .valid (w_valid)
    );

    always_comb begin
        w_sel_desc = mk_desc(
            req_enc_used[w_idx],
            req_tag[{w_idx, 2'b00} +: 4],
            req_len[{w_idx, 3'b000} +: 8]
        );
    end

    // The controller must report idle before a new packet is granted,
    // which also covers a reset that landed mid-packet.
    assign w_grant    = (r_state == S_IDLE) && w_valid && dl_done;
    assign w_complete = (r_state == S_WAIT_DONE) && dl_done;
    assign w_finish   = w_complete | w_expire;
    assign w_gap_en   = (gap_cycles != '0);
    assign w_cur_oh   = ONE << r_cur_idx;

`ifdef DL_SCHED_WDOG_EN
    logic [WDOG_WIDTH-1:0] r_wdog;
    logic [WDOG_WIDTH-1:0] w_wdog_inc;
    logic                  w_in_wait;

    assign w_in_wait  = (r_state == S_WAIT_BUSY) ||
                        (r_state == S_WAIT_DONE);
    assign w_wdog_inc = r_wdog + 1'b1;
    // a real completion on the same edge wins over expiry
    assign w_expire   = w_in_wait && (wdog_cycles != '0) &&
                        (w_wdog_inc >= wdog_cycles) && !w_complete;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (w_grant) begin
            r_wdog <= '0;
        end else if (w_in_wait) begin
            r_wdog <= w_wdog_inc;
        end
    end
`else
    logic w_unused_wdog;
    assign w_unused_wdog = ^wdog_cycles;
    assign w_expire      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (w_expire) begin
                    w_next = w_gap_en ? S_GAP : S_IDLE;
                end else if (!dl_done) begin
                    w_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (w_finish) begin
                    w_next = w_gap_en ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ack_nxt  = w_grant    ? w_gnt    : '0;
        w_done_nxt = w_complete ? w_cur_oh : '0;
        w_err_nxt  = w_expire   ? w_cur_oh : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_cur_idx <= '0;
            r_gap_cnt <= '0;
            r_desc    <= '0;
            r_start   <= 1'b0;
            r_ack     <= '0;
            r_done    <= '0;
            r_err     <= '0;
        end else begin
            r_start <= w_grant;
            r_ack   <= w_ack_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_grant) begin
                r_desc    <= w_sel_desc;
                r_cur_idx <= w_idx;
                r_ptr     <= (w_idx == IW'(NUM_REQ-1)) ?
                             '0 : w_idx + 1'b1;
            end
            // gap length is captured once, on entry
            if (w_finish && w_gap_en) begin
                r_gap_cnt <= gap_cycles - 1'b1;
            end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end

    assign req_ack     = r_ack;
    assign req_done    = r_done;
    assign req_err     = r_err;
    assign dl_start    = r_start;
    assign dl_enc_used = r_desc.enc_used;
    assign dl_msg_tag  = r_desc.tag;
    assign dl_msg_len  = r_desc.len;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_dl_scheduler.sv
// Bench for dl_scheduler: reset/busy-controller sequences, a table of
// round-robin grants, gap timing and the stuck-controller case.
module tb_dl_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_enc_used;
    logic [15:0] req_tag;
    logic [31:0] req_len;
    logic [7:0]  gap_cycles;
    logic [15:0] wdog_cycles;
    logic [3:0]  req_ack;
    logic [3:0]  req_done;
    logic [3:0]  req_err;
    logic        dl_start;
    logic        dl_enc_used;
    logic [3:0]  dl_msg_tag;
    logic [7:0]  dl_msg_len;
    logic        dl_done;
    logic        busy;

    dl_scheduler #(
        .NUM_REQ    (4),
        .GAP_WIDTH  (8),
        .WDOG_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_enc_used (req_enc_used),
        .req_tag      (req_tag),
        .req_len      (req_len),
        .gap_cycles   (gap_cycles),
        .wdog_cycles  (wdog_cycles),
        .req_ack      (req_ack),
        .req_done     (req_done),
        .req_err      (req_err),
        .dl_start     (dl_start),
        .dl_enc_used  (dl_enc_used),
        .dl_msg_tag   (dl_msg_tag),
        .dl_msg_len   (dl_msg_len),
        .dl_done      (dl_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // controller model: idle until dl_start, low from the next
    // cycle for busy_len cycles, then idle again
    bit   model_en = 1'b0;
    logic m_done   = 1'b1;
    logic man_done = 1'b0;
    int   m_cnt    = 0;
    int   m_rise   = 0;
    int   busy_len = 100;

    assign dl_done = model_en ? m_done : man_done;

    always @(negedge clk) begin
        if (model_en) begin
            if (dl_start) begin
                m_cnt = busy_len + 1;
            end else if (m_cnt > 0) begin
                m_cnt--;
                m_done = (m_cnt == 0);
                if (m_cnt == 0) m_rise = cyc;
            end
        end
    end

    int         n_done = 0;
    int         n_err  = 0;
    int         err_cyc = -1;
    logic [3:0] err_val = '0;

    always @(negedge clk) begin
        if (req_done != 4'd0) n_done++;
        if (req_err != 4'd0) begin
            n_err++;
            err_cyc = cyc;
            err_val = req_err;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_start(output int c, output bit ok);
        ok = 1'b0;
        c  = -1;
        for (int k = 0; k < 400; k++) begin
            step();
            if (dl_start) begin
                ok = 1'b1;
                c  = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done(output int c, output logic [3:0] v,
                             output bit ok);
        ok = 1'b0;
        c  = -1;
        v  = '0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (req_done != 4'd0) begin
                ok = 1'b1;
                c  = cyc;
                v  = req_done;
                break;
            end
        end
    endtask

    function automatic logic [26:0] all_outs();
        return {dl_start, req_ack, req_done, req_err, dl_enc_used,
                dl_msg_tag, dl_msg_len, busy};
    endfunction

    typedef struct {
        logic [3:0] req;
        logic [3:0] ack;
        logic       enc;
        logic [3:0] tag;
        logic [7:0] len;
    } vec_t;

    vec_t vt[10];

    initial begin
        int         s;
        int         c;
        int         d;
        int         n0;
        int         e0;
        int         cnt;
        bit         ok;
        logic [3:0] v;

        // requester fields: r0 enc1/5/56, r1 enc0/9/200,
        // r2 enc1/12/17, r3 enc0/3/255
        vt[0] = '{4'b0001, 4'b0001, 1'b1, 4'd5,  8'd56};
        vt[1] = '{4'b1111, 4'b0010, 1'b0, 4'd9,  8'd200};
        vt[2] = '{4'b1111, 4'b0100, 1'b1, 4'd12, 8'd17};
        vt[3] = '{4'b1111, 4'b1000, 1'b0, 4'd3,  8'd255};
        vt[4] = '{4'b1111, 4'b0001, 1'b1, 4'd5,  8'd56};
        vt[5] = '{4'b1001, 4'b1000, 1'b0, 4'd3,  8'd255};
        vt[6] = '{4'b0110, 4'b0010, 1'b0, 4'd9,  8'd200};
        vt[7] = '{4'b0010, 4'b0010, 1'b0, 4'd9,  8'd200};
        vt[8] = '{4'b0100, 4'b0100, 1'b1, 4'd12, 8'd17};
        vt[9] = '{4'b0001, 4'b0001, 1'b1, 4'd5,  8'd56};

        rst          = 1'b1;
        req          = 4'd0;
        req_enc_used = 4'b0101;
        req_tag      = {4'd3, 4'd12, 4'd9, 4'd5};
        req_len      = {8'd255, 8'd17, 8'd200, 8'd56};
        gap_cycles   = 8'd0;
        wdog_cycles  = 16'd50;
        man_done     = 1'b0;
        repeat (3) step();
        chk("reset_outs", 64'(all_outs()), 64'd0);

        // controller busy out of reset: request must wait
        req = 4'b0001;
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            step();
            if (dl_start) cnt++;
        end
        chk("no_grant_ctrl_busy", 64'(cnt), 64'd0);
        chk("idle_busy_low", 64'(busy), 64'd0);
        man_done = 1'b1;
        s = cyc;
        wait_start(c, ok);
        chk("grant_after_idle_to", 64'(ok), 64'd1);
        chk("grant_after_idle_lat", 64'(c), 64'(s + 1));
        chk("grant_after_idle_ack", 64'(req_ack), 64'b0001);

        // reset while waiting for completion
        step();
        man_done = 1'b0;
        req = 4'd0;
        repeat (5) step();
        chk("wait_done_busy", 64'(busy), 64'd1);
        n0  = n_done;
        rst = 1'b1;
        step();
        chk("midpkt_reset_outs", 64'(all_outs()), 64'd0);
        rst = 1'b0;
        req = 4'b1111;
        cnt = 0;
        repeat (5) begin
            step();
            if (dl_start) cnt++;
        end
        chk("no_grant_after_abort", 64'(cnt), 64'd0);
        man_done = 1'b1;
        s = cyc;
        wait_start(c, ok);
        chk("post_abort_grant_lat", 64'(c), 64'(s + 1));
        chk("post_abort_ptr0", 64'(req_ack), 64'b0001);
        chk("no_done_for_abort", 64'(n_done), 64'(n0));
        step();
        req = 4'd0;
        man_done = 1'b0;
        repeat (3) step();
        man_done = 1'b1;
        s = cyc;
        wait_done(d, v, ok);
        chk("manual_done_lat", 64'(d), 64'(s + 1));
        chk("manual_done_idx", 64'(v), 64'b0001);

        // clean start for the grant table
        rst = 1'b1;
        repeat (2) step();
        m_done   = 1'b1;
        m_cnt    = 0;
        model_en = 1'b1;
        rst      = 1'b0;

        for (int i = 0; i < 10; i++) begin
            req = vt[i].req;
            s = cyc;
            wait_start(c, ok);
            chk($sformatf("v%0d_start_to", i), 64'(ok), 64'd1);
            chk($sformatf("v%0d_start_lat", i), 64'(c), 64'(s + 1));
            chk($sformatf("v%0d_ack", i), 64'(req_ack), 64'(vt[i].ack));
            chk($sformatf("v%0d_desc", i),
                64'({dl_enc_used, dl_msg_tag, dl_msg_len}),
                64'({vt[i].enc, vt[i].tag, vt[i].len}));
            step();
            chk($sformatf("v%0d_pulse", i),
                64'({dl_start, req_ack}), 64'd0);
            req = 4'd0;
            wait_done(d, v, ok);
            chk($sformatf("v%0d_done_to", i), 64'(ok), 64'd1);
            chk($sformatf("v%0d_done_idx", i), 64'(v), 64'(vt[i].ack));
            chk($sformatf("v%0d_done_lat", i), 64'(d), 64'(m_rise + 1));
            chk($sformatf("v%0d_desc_hold", i),
                64'({dl_enc_used, dl_msg_tag, dl_msg_len}),
                64'({vt[i].enc, vt[i].tag, vt[i].len}));
        end

        // gap of 10, changed mid-gap (must not matter)
        gap_cycles = 8'd10;
        req = 4'b0001;
        wait_start(c, ok);
        chk("gap_first_ack", 64'(req_ack), 64'b0001);
        wait_done(d, v, ok);
        chk("gap_first_done", 64'(v), 64'b0001);
        step();
        gap_cycles = 8'd0;
        chk("gap_busy", 64'(busy), 64'd1);
        wait_start(c, ok);
        chk("gap_next_start", 64'(c), 64'(d + 11));
        step();
        req = 4'd0;
        wait_done(d, v, ok);
        chk("gap_second_done", 64'(v), 64'b0001);

        // controller stuck busy after a grant
        model_en = 1'b0;
        man_done = 1'b1;
        req = 4'b0100;
        wait_start(s, ok);
        chk("stuck_ack", 64'(req_ack), 64'b0100);
        step();
        man_done = 1'b0;
        req = 4'd0;
        n0 = n_done;
        e0 = n_err;
        repeat (150) step();
        chk("stuck_no_done", 64'(n_done), 64'(n0));
`ifdef DL_SCHED_WDOG_EN
        chk("wdog_err_count", 64'(n_err - e0), 64'd1);
        chk("wdog_err_cyc", 64'(err_cyc), 64'(s + 50));
        chk("wdog_err_idx", 64'(err_val), 64'b0100);
        chk("wdog_back_idle", 64'(busy), 64'd0);
`else
        chk("nowdog_no_err", 64'(n_err), 64'(e0));
        chk("nowdog_still_busy", 64'(busy), 64'd1);
        chk("nowdog_err_low", 64'(req_err), 64'd0);
`endif
        man_done = 1'b1;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
